// File: rtl/btb_update_ctrl_if.sv
// ---------------------------------------------------------------------------
// btb_update_ctrl_if
//   Branch-resolution channel from the EX stage into the branch target table
//   controller. It is a valid/ready handshake: EX holds every upd_* field
//   stable until it sees upd_ready high at a rising edge with upd_valid set.
//
//   upd_valid   EX -> ctrl   a resolved branch is presented
//   upd_ready   ctrl -> EX   controller accepts the resolution this cycle
//   upd_pc      EX -> ctrl   PC of the resolved branch
//   upd_target  EX -> ctrl   resolved branch target
//   upd_taken   EX -> ctrl   branch was taken
// ---------------------------------------------------------------------------
interface btb_update_ctrl_if;
  logic        upd_valid;
  logic        upd_ready;
  logic [31:0] upd_pc;
  logic [31:0] upd_target;
  logic        upd_taken;

  // EX stage side.
  modport master (
    output upd_valid, upd_pc, upd_target, upd_taken,
    input  upd_ready
  );

  // Table controller side.
  modport slave (
    input  upd_valid, upd_pc, upd_target, upd_taken,
    output upd_ready
  );
endinterface

// File: rtl/btb_update_ctrl.sv
// ---------------------------------------------------------------------------
// btb_update_ctrl
//   Owns a direct-mapped branch target table and sequences every access to it:
//   - combinational fetch lookup (bp_hit_o / bp_pc_o) on the current contents,
//   - one EX resolution at a time, applied as a read-modify-write of a 2-bit
//     saturating counter (IDLE -> WRITE -> IDLE, one update per two cycles),
//   - a flush sweep that clears one entry per cycle (CLEAR, ENTRIES cycles).
//
// Ports
//   CLK           in   clock, rising edge
//   RST           in   synchronous, active-high reset
//   curr_pc_i     in   fetch PC
//   bp_pc_o       out  predicted next PC
//   bp_hit_o      out  lookup matched a valid entry
//   invalidate_i  in   flush request; highest priority in every state
//   busy_o        out  clear sweep in progress
//   upd           slave side of the EX resolution handshake
// ---------------------------------------------------------------------------
module btb_update_ctrl #(
  parameter int ENTRIES = 4,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [31:0]               curr_pc_i,
  output logic [31:0]               bp_pc_o,
  output logic                      bp_hit_o,
  input  logic                      invalidate_i,
  output logic                      busy_o,
  btb_update_ctrl_if.slave          upd
);

  localparam int TAG_W = 32 - IDX_W - 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_CLEAR = 2'd2
  } state_e;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_e             state_q, state_d;
  logic [IDX_W-1:0]   clr_idx_q, clr_idx_d;

  // Latched resolution, consumed in WRITE.
  logic [IDX_W-1:0]   u_idx_q;
  logic [TAG_W-1:0]   u_tag_q;
  logic [31:0]        u_tgt_q;
  logic               u_taken_q;

  // Table storage.
  logic               valid_q [ENTRIES];
  logic [1:0]         cnt_q   [ENTRIES];
  logic [TAG_W-1:0]   tag_q   [ENTRIES];
  logic [31:0]        tgt_q   [ENTRIES];

  // Single table write port, shared by WRITE and CLEAR.
  logic               wr_en;
  logic [IDX_W-1:0]   wr_idx;
  logic               wr_valid;
  logic [1:0]         wr_cnt;
  logic [TAG_W-1:0]   wr_tag;
  logic [31:0]        wr_tgt;

  logic               accept;
  logic               u_hit;

  // Low PC bits are the instruction byte offset and never index the table.
  logic               unused_pc_bits;
  assign unused_pc_bits = ^{curr_pc_i[1:0], upd.upd_pc[1:0]};

  // -------------------------------------------------------------------------
  // Fetch lookup: reads the registered table, so a WRITE in the same cycle is
  // not visible until the following cycle.
  // -------------------------------------------------------------------------
  logic [IDX_W-1:0]   l_idx;
  logic [TAG_W-1:0]   l_tag;

  assign l_idx    = curr_pc_i[IDX_W+1:2];
  assign l_tag    = curr_pc_i[31:IDX_W+2];
  assign bp_hit_o = valid_q[l_idx] && (tag_q[l_idx] == l_tag) && (state_q != ST_CLEAR);
  assign bp_pc_o  = (bp_hit_o && cnt_q[l_idx][1]) ? tgt_q[l_idx] : curr_pc_i + 32'd4;

  assign busy_o        = (state_q == ST_CLEAR);
  assign upd.upd_ready = (state_q == ST_IDLE) && !invalidate_i;
  assign accept        = upd.upd_valid && upd.upd_ready;

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    state_d   = state_q;
    clr_idx_d = clr_idx_q;

    if (invalidate_i) begin
      // Flush wins everywhere: a pending update is dropped and the sweep
      // (re)starts at index 0.
      state_d   = ST_CLEAR;
      clr_idx_d = '0;
    end else begin
      unique case (state_q)
        ST_IDLE:  if (accept) state_d = ST_WRITE;
        ST_WRITE: state_d = ST_IDLE;
        ST_CLEAR: begin
          if (clr_idx_q == IDX_W'(ENTRIES - 1)) begin
            state_d = ST_IDLE;
          end else begin
            clr_idx_d = clr_idx_q + IDX_W'(1);
          end
        end
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Table write port
  // -------------------------------------------------------------------------
  assign u_hit = valid_q[u_idx_q] && (tag_q[u_idx_q] == u_tag_q);

  always_comb begin
    wr_en    = 1'b0;
    wr_idx   = u_idx_q;
    wr_valid = valid_q[u_idx_q];
    wr_cnt   = cnt_q[u_idx_q];
    wr_tag   = tag_q[u_idx_q];
    wr_tgt   = tgt_q[u_idx_q];

    if (state_q == ST_WRITE && !invalidate_i) begin
      if (u_hit) begin
        wr_en = 1'b1;
        if (u_taken_q) begin
          wr_cnt = (cnt_q[u_idx_q] == 2'b11) ? 2'b11 : cnt_q[u_idx_q] + 2'b01;
          wr_tgt = u_tgt_q;
        end else begin
          wr_cnt = (cnt_q[u_idx_q] == 2'b00) ? 2'b00 : cnt_q[u_idx_q] - 2'b01;
        end
      end else if (u_taken_q) begin
        // Allocate (or replace an aliasing entry) as weakly taken.
        wr_en    = 1'b1;
        wr_valid = 1'b1;
        wr_cnt   = 2'b10;
        wr_tag   = u_tag_q;
        wr_tgt   = u_tgt_q;
      end
      // Miss and not taken: nothing worth remembering.
    end else if (state_q == ST_CLEAR) begin
      wr_en    = 1'b1;
      wr_idx   = clr_idx_q;
      wr_valid = 1'b0;
      wr_cnt   = 2'b01;
      wr_tag   = '0;
      wr_tgt   = '0;
    end
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      clr_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      u_idx_q   <= '0;
      u_tag_q   <= '0;
      u_tgt_q   <= '0;
      u_taken_q <= 1'b0;
    end else if (accept) begin
      u_idx_q   <= upd.upd_pc[IDX_W+1:2];
      u_tag_q   <= upd.upd_pc[31:IDX_W+2];
      u_tgt_q   <= upd.upd_target;
      u_taken_q <= upd.upd_taken;
    end
  end

  // NOTE: the table is small and lives in flops, and a reset must leave it
  // fully invalid with counters at 2'b01, so every entry is reset here rather
  // than relying on a clear sweep after reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        cnt_q[i]   <= 2'b01;
        tag_q[i]   <= '0;
        tgt_q[i]   <= '0;
      end
    end else if (wr_en) begin
      valid_q[wr_idx] <= wr_valid;
      cnt_q[wr_idx]   <= wr_cnt;
      tag_q[wr_idx]   <= wr_tag;
      tgt_q[wr_idx]   <= wr_tgt;
    end
  end

endmodule

// File: tb/tb_btb_update_ctrl.sv
// ---------------------------------------------------------------------------
// tb_btb_update_ctrl
//   Directed bench for btb_update_ctrl. Inputs change on the falling edge and
//   outputs are sampled 1 ns later, well away from the rising edge. Counter
//   values are observed through the prediction (cnt[1]) after chosen update
//   sequences; expected values are worked out by hand next to each step.
// ---------------------------------------------------------------------------
module tb_btb_update_ctrl;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] curr_pc;
  logic [31:0] bp_pc;
  logic        bp_hit;
  logic        invalidate;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  btb_update_ctrl_if u_if ();

  btb_update_ctrl dut (
    .CLK          (CLK),
    .RST          (RST),
    .curr_pc_i    (curr_pc),
    .bp_pc_o      (bp_pc),
    .bp_hit_o     (bp_hit),
    .invalidate_i (invalidate),
    .busy_o       (busy),
    .upd          (u_if.slave)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Set the fetch PC and check the combinational prediction.
  task automatic lookup(input string tag, input logic [31:0] pc,
                        input logic exp_hit, input logic [31:0] exp_pc);
    curr_pc = pc;
    #1;
    check({tag, "_hit"}, {31'd0, bp_hit}, {31'd0, exp_hit});
    check({tag, "_pc"}, bp_pc, exp_pc);
  endtask

  // One handshake and its WRITE cycle; returns at the falling edge after
  // the write edge, with the controller back in IDLE.
  task automatic update(input string tag, input logic [31:0] pc,
                        input logic [31:0] tgt, input logic taken);
    @(negedge CLK);
    u_if.upd_valid  = 1'b1;
    u_if.upd_pc     = pc;
    u_if.upd_target = tgt;
    u_if.upd_taken  = taken;
    #1;
    check({tag, "_rdy"}, {31'd0, u_if.upd_ready}, 32'd1);
    @(negedge CLK);
    u_if.upd_valid = 1'b0;
    @(negedge CLK);
  endtask

  // Count falling edges with busy high, bounded; returns at the first edge
  // where busy is low.
  task automatic count_busy(input string tag, input int exp_cycles);
    int cycles = 0;
    while (busy && cycles < 32) begin
      cycles++;
      @(negedge CLK);
    end
    check(tag, cycles, exp_cycles);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    RST             = 1'b1;
    invalidate      = 1'b0;
    curr_pc         = 32'h0000_0040;
    u_if.upd_valid  = 1'b0;
    u_if.upd_pc     = '0;
    u_if.upd_target = '0;
    u_if.upd_taken  = 1'b0;
    repeat (2) @(negedge CLK);
    RST = 1'b0;

    // 1. Reset state.
    lookup("rst", 32'h0000_0040, 1'b0, 32'h0000_0044);
    check("rst_rdy", {31'd0, u_if.upd_ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    lookup("wrap", 32'hFFFF_FFFC, 1'b0, 32'h0000_0000);

    // 2. Allocate (cnt 10), then strengthen (cnt 11).
    update("a1", 32'h40, 32'h100, 1'b1);
    lookup("alloc", 32'h40, 1'b1, 32'h100);
    update("a2", 32'h40, 32'h100, 1'b1);       // 11
    update("a3", 32'h40, 32'h100, 1'b1);       // stays 11
    update("a4", 32'h40, 32'h100, 1'b0);       // 10 (a wrap to 00 would give 00)
    lookup("sat_hi", 32'h40, 1'b1, 32'h100);

    // 3. Walk down and saturate at 00.
    update("d1", 32'h40, 32'h100, 1'b0);       // 01
    lookup("cnt01", 32'h40, 1'b1, 32'h44);
    update("d2", 32'h40, 32'h100, 1'b0);       // 00
    lookup("cnt00", 32'h40, 1'b1, 32'h44);
    update("d3", 32'h40, 32'h100, 1'b0);       // stays 00
    update("u1", 32'h40, 32'h100, 1'b1);       // 01 (a wrap to 11 would predict taken)
    lookup("sat_lo", 32'h40, 1'b1, 32'h44);
    update("u2", 32'h40, 32'h100, 1'b1);       // 10
    lookup("cnt10", 32'h40, 1'b1, 32'h100);

    // 4. upd_valid held three cycles: ready 1,0,1 and exactly two writes.
    update("u3", 32'h40, 32'h100, 1'b1);       // 11
    @(negedge CLK);
    u_if.upd_valid  = 1'b1;
    u_if.upd_pc     = 32'h40;
    u_if.upd_target = 32'h100;
    u_if.upd_taken  = 1'b0;
    #1 check("hold_rdy0", {31'd0, u_if.upd_ready}, 32'd1);
    @(negedge CLK);
    #1 check("hold_rdy1", {31'd0, u_if.upd_ready}, 32'd0);
    @(negedge CLK);
    #1 check("hold_rdy2", {31'd0, u_if.upd_ready}, 32'd1);
    @(negedge CLK);
    u_if.upd_valid = 1'b0;
    #1 check("hold_rdy3", {31'd0, u_if.upd_ready}, 32'd0);
    @(negedge CLK);
    // Two writes: 11 -> 10 -> 01 (one write leaves 10, three leave 00).
    lookup("hold_cnt", 32'h40, 1'b1, 32'h44);
    update("h1", 32'h40, 32'h100, 1'b1);       // 10
    lookup("hold_cnt2", 32'h40, 1'b1, 32'h100);

    // Lookup during WRITE sees pre-write contents (0x58 -> idx 2).
    @(negedge CLK);
    u_if.upd_valid  = 1'b1;
    u_if.upd_pc     = 32'h58;
    u_if.upd_target = 32'h200;
    u_if.upd_taken  = 1'b1;
    @(negedge CLK);
    u_if.upd_valid = 1'b0;
    lookup("pre_wr", 32'h58, 1'b0, 32'h5C);
    @(negedge CLK);
    lookup("post_wr", 32'h58, 1'b1, 32'h200);

    // Index alias: 0x50 maps to idx 0 with a different tag and replaces 0x40.
    update("al", 32'h50, 32'h300, 1'b1);
    lookup("alias_old", 32'h40, 1'b0, 32'h44);
    lookup("alias_new", 32'h50, 1'b1, 32'h300);

    // Not-taken miss writes nothing (idx 3 stays invalid).
    update("nt_miss", 32'h4C, 32'h900, 1'b0);
    lookup("nt_miss", 32'h4C, 1'b0, 32'h50);

    // 5. Fill all four entries, then flush.
    for (int i = 0; i < 4; i++) begin
      update("fill", 32'h40 + 32'(4 * i), 32'h1000 + 32'(16 * i), 1'b1);
    end
    for (int i = 0; i < 4; i++) begin
      lookup("filled", 32'h40 + 32'(4 * i), 1'b1, 32'h1000 + 32'(16 * i));
    end
    @(negedge CLK);
    invalidate      = 1'b1;
    u_if.upd_valid  = 1'b1;                    // collides with the flush
    u_if.upd_pc     = 32'h60;
    u_if.upd_target = 32'h2000;
    u_if.upd_taken  = 1'b1;
    #1 check("inv_rdy", {31'd0, u_if.upd_ready}, 32'd0);
    @(negedge CLK);
    invalidate     = 1'b0;
    u_if.upd_valid = 1'b0;
    // First sweep cycle clears idx 0; idx 3 is still valid but must miss.
    lookup("busy_miss", 32'h4C, 1'b0, 32'h50);
    count_busy("sweep_len", 4);
    for (int i = 0; i < 4; i++) begin
      lookup("cleared", 32'h40 + 32'(4 * i), 1'b0, 32'h44 + 32'(4 * i));
    end
    lookup("dropped", 32'h60, 1'b0, 32'h64);

    // Restart at sweep cycle 2: busy 2 cycles, then 4 more.
    @(negedge CLK);
    invalidate = 1'b1;
    @(negedge CLK);
    invalidate = 1'b0;
    #1 check("restart_c1", {31'd0, busy}, 32'd1);
    @(negedge CLK);
    invalidate = 1'b1;
    #1 check("restart_c2", {31'd0, busy}, 32'd1);
    @(negedge CLK);
    invalidate = 1'b0;
    count_busy("restart_len", 4);

    // 6. Invalidate during WRITE drops the update.
    @(negedge CLK);
    u_if.upd_valid  = 1'b1;
    u_if.upd_pc     = 32'h44;
    u_if.upd_target = 32'h500;
    u_if.upd_taken  = 1'b1;
    @(negedge CLK);
    u_if.upd_valid = 1'b0;
    invalidate     = 1'b1;
    @(negedge CLK);
    invalidate = 1'b0;
    #1 check("wr_inv_busy", {31'd0, busy}, 32'd1);
    count_busy("wr_inv_len", 4);
    lookup("wr_dropped", 32'h44, 1'b0, 32'h48);

    // RST during CLEAR: IDLE next cycle and the whole table is reset.
    update("pre_rst", 32'h4C, 32'h600, 1'b1);
    lookup("pre_rst", 32'h4C, 1'b1, 32'h600);
    @(negedge CLK);
    invalidate = 1'b1;
    @(negedge CLK);
    invalidate = 1'b0;
    RST        = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    #1;
    check("rst_clr_busy", {31'd0, busy}, 32'd0);
    check("rst_clr_rdy", {31'd0, u_if.upd_ready}, 32'd1);
    lookup("rst_clr_tbl", 32'h4C, 1'b0, 32'h50);
    update("post_rst", 32'h40, 32'h700, 1'b1);
    lookup("post_rst", 32'h40, 1'b1, 32'h700);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
